calc_tx_serializer: RTL

//  Buffered, parametrised output serializer for the binary calculator.
//  - Result words (packed {Sel,InA,InB,Result}) are written into a DEPTH-entry FIFO.
//  - Each word is shifted out SBITS bits per ClkTx period, at a programmable rate.
//  - Generalises the fixed single-word DataOut/ClkTx/DoutValid path with buffering,

---
 rtl/calc_tx_serializer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_tx_serializer.sv
// calc_tx_serializer: buffered slice serializer for calculator result words.
// A DEPTH-entry FIFO feeds a shift FSM that emits SBITS-wide slices, each held
// for 2*D clocks with a ClkTx strobe rising halfway through the slice.
// Optional feature macro: TX_PARITY_EN appends an even-parity slice to each word.
module calc_tx_serializer #(
  parameter int unsigned WORDW = 32,
  parameter int unsigned SBITS = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIVW  = 8,
  parameter int unsigned LVLW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             config_div_i,
  input  logic [DIVW-1:0]  div_i,
  input  logic             msb_first_i,
  input  logic             wr_en_i,
  input  logic [WORDW-1:0] wr_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVLW-1:0]  level_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             clk_tx_o,
  output logic             dout_valid_o,
  output logic [SBITS-1:0] data_out_o
);

  localparam int unsigned N    = WORDW / SBITS;
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned KW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNTW = DIVW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
`ifdef TX_PARITY_EN
    ST_PAR,
`endif
    ST_GAP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [WORDW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVLW-1:0]  level_q, level_d;
  logic             full_q, empty_q, overflow_q;
  logic             push, pop;
  logic [WORDW-1:0] head;

  state_t state_q;

  assign push = wr_en_i & ~full_q;
  assign pop  = (state_q == ST_LOAD);
  assign head = mem_q[rd_ptr_q];

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Word storage; contents need no reset since Level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVLW'(1);
    else if (!push && pop) level_d = level_q - LVLW'(1);
  end

  // Pointers, registered flags and the overflow pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      level_q    <= level_d;
      full_q     <= (level_d == LVLW'(DEPTH));
      empty_q    <= (level_d == '0);
      overflow_q <= wr_en_i & full_q;
    end
  end

  // ---------------------------------------------------------------- shifter
  logic [DIVW-1:0]  div_q, pend_q;
  logic             pend_v_q;
  logic [WORDW-1:0] sreg_q, sreg_n;
  logic             msb_q;
  logic [KW-1:0]    k_q;
  logic [CNTW-1:0]  cnt_q;
  logic             busy_q, clk_tx_q, dout_valid_q;
  logic [SBITS-1:0] data_out_q;
  logic [DIVW-1:0]  deff;
  logic             slice_end, rise;
`ifdef TX_PARITY_EN
  logic             par_q;
`endif

  assign deff      = (div_q == '0) ? DIVW'(1) : div_q;
  assign slice_end = (cnt_q == ({deff, 1'b0} - CNTW'(1)));
  assign rise      = (cnt_q == ({1'b0, deff} - CNTW'(1)));
  assign sreg_n    = msb_q ? (sreg_q << SBITS) : (sreg_q >> SBITS);

  function automatic logic [SBITS-1:0] first_slice(input logic [WORDW-1:0] w,
                                                    input logic             msb);
    return msb ? w[WORDW-1 -: SBITS] : w[SBITS-1:0];
  endfunction

  // Transmit FSM with registered strobe, valid and slice outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      div_q        <= DIVW'(1);
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      sreg_q       <= '0;
      msb_q        <= 1'b0;
      k_q          <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      clk_tx_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      data_out_q   <= '0;
`ifdef TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      // Rate requests made mid-word wait until the FSM is back in IDLE.
      if (config_div_i && state_q != ST_IDLE && state_q != ST_GAP) begin
        pend_q   <= div_i;
        pend_v_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (config_div_i) div_q <= div_i;
          if (!empty_q) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          sreg_q       <= head;
          msb_q        <= msb_first_i;
          k_q          <= '0;
          cnt_q        <= '0;
          clk_tx_q     <= 1'b0;
          dout_valid_q <= 1'b1;
          data_out_q   <= first_slice(head, msb_first_i);
`ifdef TX_PARITY_EN
          par_q        <= ^head;
`endif
          state_q      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (slice_end) begin
            cnt_q    <= '0;
            clk_tx_q <= 1'b0;
            if (k_q == KW'(N - 1)) begin
`ifdef TX_PARITY_EN
              data_out_q <= SBITS'(par_q);
              state_q    <= ST_PAR;
`else
              dout_valid_q <= 1'b0;
              data_out_q   <= '0;
              state_q      <= ST_GAP;
`endif
            end else begin
              k_q        <= k_q + KW'(1);
              sreg_q     <= sreg_n;
              data_out_q <= first_slice(sreg_n, msb_q);
            end
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
            if (rise) clk_tx_q <= 1'b1;
          end
        end
`ifdef TX_PARITY_EN
        ST_PAR: begin
          if (slice_end) begin
            cnt_q        <= '0;
            clk_tx_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            data_out_q   <= '0;
            state_q      <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
            if (rise) clk_tx_q <= 1'b1;
          end
        end
`endif
        ST_GAP: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          pend_v_q <= 1'b0;
          if (config_div_i)  div_q <= div_i;
          else if (pend_v_q) div_q <= pend_q;
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          clk_tx_q     <= 1'b0;
          dout_valid_q <= 1'b0;
          data_out_q   <= '0;
        end
      endcase
    end
  end

  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = busy_q;
  assign clk_tx_o     = clk_tx_q;
  assign dout_valid_o = dout_valid_q;
  assign data_out_o   = data_out_q;

endmodule
